reset_release_sequencer: RTL

RESET_RELEASE_SEQUENCER -- requirements
Module: reset_release_sequencer

---
 rtl/reset_release_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer.
// Holds every channel reset asserted for a minimum time, then releases the
// channels one at a time in ascending order with a fixed spacing. With
// USE_READY set, each release waits for that channel's acknowledge (or a
// bounded timeout) before the next stage starts. A synchronous request
// re-runs the whole sequence from the beginning.
//
// Handshake: ready_in[k] is a level acknowledge, not a valid/ready pair. It
// is only looked at while the sequencer waits on channel k (the channel just
// released). A high level on the sampling edge counts as the acknowledge.
// Bits for any other channel, and all bits when USE_READY=0, are ignored.

module reset_release_sequencer #(
  parameter int NUM_CHANNELS  = 4,
  parameter int ASSERT_HOLD   = 16,
  parameter int STAGE_DELAY   = 1000,
  parameter bit USE_READY     = 1'b0,
  parameter int READY_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    reset_req_in,
  input  logic [NUM_CHANNELS-1:0] ready_in,
  output logic [NUM_CHANNELS-1:0] reset_n_out,
  output logic                    all_released,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_STAGE      = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  // One shared counter serves the hold, the stage spacing and the timeout.
  localparam int MAX_AS  = (ASSERT_HOLD > STAGE_DELAY) ? ASSERT_HOLD : STAGE_DELAY;
  localparam int MAX_ALL = (MAX_AS > READY_TIMEOUT) ? MAX_AS : READY_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(ASSERT_HOLD - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHANNELS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    ready_sel;
  logic [NUM_CHANNELS-1:0] release_mask;
  logic                    is_last;

  assign fsm_state = state;
  assign is_last   = (idx == LAST_IDX);

  // Select the acknowledge and the release bit of the current channel only.
  always_comb begin
    ready_sel    = 1'b0;
    release_mask = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (IDX_W'(k) == idx) begin
        ready_sel       = ready_in[k];
        release_mask[k] = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs; reset and request restart it.
  always_ff @(posedge clk) begin
    if (!reset_n || reset_req_in) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      reset_n_out  <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_STAGE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_STAGE: begin
          if (cnt == STAGE_LAST) begin
            cnt         <= '0;
            reset_n_out <= reset_n_out | release_mask;
            if (is_last) begin
              all_released <= 1'b1;
            end
            if (USE_READY) begin
              state <= ST_WAIT_READY;
            end else if (is_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_READY: begin
          if (ready_sel || (cnt == TIMEOUT_LAST)) begin
            cnt <= '0;
            if (!ready_sel) begin
              timeout_err <= 1'b1;
            end
            if (is_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_STAGE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_DONE;
        end
      endcase
    end
  end

endmodule
